// File: rtl/pin_synch_filter_if.sv
// ---------------------------------------------------------------------------
// pin_synch_filter_if
//   Bundles the per-channel pin signals of pin_synch_filter into one port.
//
//   Optional feature macro: PIN_SYNCH_STICKY_EN
//     When defined, the interface also carries i_clrSticky / o_sticky.
//
//   Signals (all NUM_CH wide):
//     i_asynchLines  raw external lines, asynchronous to the filter clock
//     o_synchLines   synchronized, unfiltered lines
//     o_level        debounced level
//     o_rise         one-cycle pulse on a 0->1 change of o_level
//     o_fall         one-cycle pulse on a 1->0 change of o_level
//     i_clrSticky    per-channel sticky clear   (PIN_SYNCH_STICKY_EN only)
//     o_sticky       per-channel sticky flag    (PIN_SYNCH_STICKY_EN only)
//
//   Modports:
//     master  the side that drives the pins and consumes the filtered view
//     slave   the filter itself
// ---------------------------------------------------------------------------
interface pin_synch_filter_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] i_asynchLines;
  logic [NUM_CH-1:0] o_synchLines;
  logic [NUM_CH-1:0] o_level;
  logic [NUM_CH-1:0] o_rise;
  logic [NUM_CH-1:0] o_fall;
`ifdef PIN_SYNCH_STICKY_EN
  logic [NUM_CH-1:0] i_clrSticky;
  logic [NUM_CH-1:0] o_sticky;
`endif

`ifdef PIN_SYNCH_STICKY_EN
  modport master (
    output i_asynchLines,
    output i_clrSticky,
    input  o_synchLines,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  o_sticky
  );

  modport slave (
    input  i_asynchLines,
    input  i_clrSticky,
    output o_synchLines,
    output o_level,
    output o_rise,
    output o_fall,
    output o_sticky
  );
`else
  modport master (
    output i_asynchLines,
    input  o_synchLines,
    input  o_level,
    input  o_rise,
    input  o_fall
  );

  modport slave (
    input  i_asynchLines,
    output o_synchLines,
    output o_level,
    output o_rise,
    output o_fall
  );
`endif

endinterface

// File: rtl/pin_synch_filter.sv
// ---------------------------------------------------------------------------
// pin_synch_filter
//   Multi-channel pin conditioner: each of NUM_CH asynchronous lines runs
//   through a STAGES-deep synchronizer chain and then a per-channel
//   debounce filter that only accepts a new value after it has been seen on
//   DB_CYCLES consecutive edges. Emits the filtered level plus registered
//   one-cycle rise/fall pulses per channel.
//
//   Optional feature macro: PIN_SYNCH_STICKY_EN
//     Adds a per-channel sticky change flag (o_sticky) that sets on any
//     rise/fall pulse and clears when i_clrSticky is sampled high; a set
//     coinciding with a clear wins.
//
//   Ports:
//     i_clk   system clock, rising edge
//     i_rstn  asynchronous active-low reset
//     bus     pin_synch_filter_if.slave
//               i_asynchLines  raw lines in
//               o_synchLines   last synchronizer stage
//               o_level        debounced level
//               o_rise/o_fall  one-cycle change pulses
//               i_clrSticky/o_sticky  (PIN_SYNCH_STICKY_EN only)
//
//   Parameters:
//     NUM_CH     number of channels (>=1)
//     STAGES     synchronizer depth (>=2)
//     DB_CYCLES  consecutive edges a new value must hold (>=1)
//     RST_VAL    reset value of synchronizer flops and filtered levels
// ---------------------------------------------------------------------------
module pin_synch_filter #(
  parameter int NUM_CH    = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 4,
  parameter bit RST_VAL   = 1'b0
) (
  input logic              i_clk,
  input logic              i_rstn,
  pin_synch_filter_if.slave bus
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Stage 0 is the flop that first samples the pin; stage STAGES-1 is S.
  logic [STAGES-1:0][NUM_CH-1:0] r_sync;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0]             r_level;
  logic [NUM_CH-1:0]             r_rise;
  logic [NUM_CH-1:0]             r_fall;

  logic [NUM_CH-1:0]             w_sNext;
  logic [NUM_CH-1:0]             w_diff;
  logic [NUM_CH-1:0]             w_accept;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_cntNext;

  // The filter evaluates the value that S takes on this very edge, so the
  // counter advances in the same edge that the new value lands in the last
  // synchronizer stage. That keeps the total pin-to-level latency at
  // STAGES + DB_CYCLES - 1 edges.
  assign w_sNext = r_sync[STAGES-2];

  // Per-channel debounce decision: clear the count when S agrees with the
  // level, count up while it disagrees, and accept the new value on the
  // DB_CYCLES-th consecutive disagreement. The >= compare keeps the counter
  // saturating rather than wrapping.
  always_comb begin
    w_diff    = w_sNext ^ r_level;
    w_accept  = '0;
    w_cntNext = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w_diff[ch]) begin
        if (r_cnt[ch] >= CNT_LAST) begin
          w_accept[ch] = 1'b1;
        end else begin
          w_cntNext[ch] = r_cnt[ch] + 1'b1;
        end
      end
    end
  end

  // Synchronizer chain, filter state and registered event pulses. Reset is
  // asynchronous, so a pending count is discarded the moment i_rstn drops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync  <= {(STAGES*NUM_CH){RST_VAL}};
      r_level <= {NUM_CH{RST_VAL}};
      r_cnt   <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], bus.i_asynchLines};
      r_level <= r_level ^ w_accept;
      r_cnt   <= w_cntNext;
      r_rise  <= w_accept & w_sNext;
      r_fall  <= w_accept & ~w_sNext;
    end
  end

  assign bus.o_synchLines = r_sync[STAGES-1];
  assign bus.o_level      = r_level;
  assign bus.o_rise       = r_rise;
  assign bus.o_fall       = r_fall;

`ifdef PIN_SYNCH_STICKY_EN
  logic [NUM_CH-1:0] r_sticky;

  // Sticky flag: set by the visible rise/fall pulse, cleared by a sampled
  // clear; the OR after the clear term makes a simultaneous set win.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~bus.i_clrSticky) | r_rise | r_fall;
    end
  end

  assign bus.o_sticky = r_sticky;
`endif

endmodule

// File: tb/tb_pin_synch_filter.sv
// ---------------------------------------------------------------------------
// tb_pin_synch_filter
//   Directed and randomized stimulus for pin_synch_filter, checked against
//   a behavioural model kept here. The model keeps the pin history as a
//   delay queue and a log of synchronized samples; a channel's level flips
//   when the last DB_CYCLES logged samples since its previous change all
//   disagree with it.
//   Honours PIN_SYNCH_STICKY_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_pin_synch_filter;

  localparam int NUM_CH    = 4;
  localparam int STAGES    = 2;
  localparam int DB_CYCLES = 4;
  localparam bit RST_VAL   = 1'b0;

  logic clk;
  logic rstn;

  int assertCount;
  int failCount;

  pin_synch_filter_if #(.NUM_CH(NUM_CH)) bus ();

  pin_synch_filter #(
    .NUM_CH   (NUM_CH),
    .STAGES   (STAGES),
    .DB_CYCLES(DB_CYCLES),
    .RST_VAL  (RST_VAL)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state.
  logic [NUM_CH-1:0] mPipe[$];
  logic [NUM_CH-1:0] mLog[$];
  int                mSince[NUM_CH];
  logic [NUM_CH-1:0] mLevel;
  logic [NUM_CH-1:0] mRise;
  logic [NUM_CH-1:0] mFall;
  logic [NUM_CH-1:0] mSticky;

  // Model: everything returns to its reset value at once.
  task automatic modelReset();
    mPipe.delete();
    for (int k = 0; k < STAGES; k++) mPipe.push_back({NUM_CH{RST_VAL}});
    mLog.delete();
    for (int ch = 0; ch < NUM_CH; ch++) mSince[ch] = 0;
    mLevel  = {NUM_CH{RST_VAL}};
    mRise   = '0;
    mFall   = '0;
    mSticky = '0;
  endtask

  // Model: one rising edge with the given pins and sticky clears.
  task automatic modelEdge(input logic [NUM_CH-1:0] lines,
                           input logic [NUM_CH-1:0] clr);
    logic [NUM_CH-1:0] prevEv;
    logic [NUM_CH-1:0] s;
    int n;
    bit allDiff;
    prevEv = mRise | mFall;
    mPipe.push_front(lines);
    void'(mPipe.pop_back());
    s = mPipe[STAGES-1];
    mLog.push_back(s);
    n = mLog.size();
    mRise = '0;
    mFall = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (n - mSince[ch] >= DB_CYCLES) begin
        allDiff = 1'b1;
        for (int j = n - DB_CYCLES; j < n; j++) begin
          if (mLog[j][ch] == mLevel[ch]) allDiff = 1'b0;
        end
        if (allDiff) begin
          mLevel[ch] = s[ch];
          if (s[ch]) mRise[ch] = 1'b1;
          else       mFall[ch] = 1'b1;
          mSince[ch] = n;
        end
      end
    end
    mSticky = (mSticky & ~clr) | prevEv;
  endtask

  task automatic checkOne(input string tag,
                          input logic [NUM_CH-1:0] obs,
                          input logic [NUM_CH-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, " synch"}, bus.o_synchLines, mPipe[STAGES-1]);
    checkOne({tag, " level"}, bus.o_level, mLevel);
    checkOne({tag, " rise"},  bus.o_rise, mRise);
    checkOne({tag, " fall"},  bus.o_fall, mFall);
    checkOne({tag, " rise&fall"}, bus.o_rise & bus.o_fall, '0);
`ifdef PIN_SYNCH_STICKY_EN
    checkOne({tag, " sticky"}, bus.o_sticky, mSticky);
`endif
  endtask

  // One clock step: drive pins, take the edge, update model, check 1 later.
  task automatic applyStimulus(input logic [NUM_CH-1:0] lines,
                               input logic [NUM_CH-1:0] clr,
                               input string tag);
    bus.i_asynchLines = lines;
`ifdef PIN_SYNCH_STICKY_EN
    bus.i_clrSticky = clr;
`endif
    @(posedge clk);
    if (rstn) modelEdge(lines, clr);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset asserted between edges, held over one edge, released.
  task automatic asyncReset(input string tag);
    rstn = 1'b0;
    #2;
    modelReset();
    checkOutput({tag, " immediate"});
    @(posedge clk);
    #1;
    checkOutput({tag, " held"});
    rstn = 1'b1;
  endtask

  initial begin
    logic [NUM_CH-1:0] lines;
    logic [NUM_CH-1:0] clr;

    assertCount = 0;
    failCount   = 0;
    rstn = 1'b0;
    bus.i_asynchLines = '1;
`ifdef PIN_SYNCH_STICKY_EN
    bus.i_clrSticky = '0;
`endif
    modelReset();

    // Reset with clocks running and all pins high.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset running");
    rstn = 1'b1;
    $display("[TB] reset released");

    // Let all levels go high, then drop reset between edges.
    for (int k = 0; k < 6; k++) applyStimulus(4'hF, '0, "all high");
    checkOne("all high level", bus.o_level, 4'hF);
    bus.i_asynchLines = '0;
    asyncReset("mid-cycle reset");

    // ch0 clean rise: S at edge 2, level and rise at edge 5.
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(4'b0001, '0, "ch0 rise");
      if (k == 2) checkOne("ch0 synch edge2", {3'b000, bus.o_synchLines[0]}, 4'b0001);
      if (k == 4) checkOne("ch0 level edge4", bus.o_level, 4'b0000);
      if (k == 5) checkOne("ch0 rise edge5", bus.o_rise, 4'b0001);
      if (k == 6) checkOne("ch0 rise edge6", bus.o_rise, 4'b0000);
    end

    // ch1 glitch of 3 samples, then a proper rise.
    for (int k = 0; k < 3; k++) applyStimulus(4'b0011, '0, "ch1 glitch");
    for (int k = 0; k < 5; k++) applyStimulus(4'b0001, '0, "ch1 glitch end");
    checkOne("ch1 glitch level", bus.o_level, 4'b0001);
    for (int k = 0; k < 7; k++) applyStimulus(4'b0011, '0, "ch1 rise");
    checkOne("ch1 level", bus.o_level, 4'b0011);

    // ch2/ch3 up, then both fall together.
    for (int k = 0; k < 7; k++) applyStimulus(4'b1111, '0, "ch23 up");
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(4'b0011, '0, "ch23 fall");
      if (k == 5) checkOne("ch23 fall pulse", bus.o_fall, 4'b1100);
    end

    // Reset while ch0 counts towards a rise; the count is discarded.
    for (int k = 0; k < 7; k++) applyStimulus(4'b0000, '0, "all low");
    for (int k = 0; k < 3; k++) applyStimulus(4'b0001, '0, "ch0 count");
    asyncReset("reset mid-count");
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(4'b0001, '0, "ch0 after reset");
      if (k == 4) checkOne("ch0 post-reset level k4", bus.o_level, 4'b0000);
      if (k == 5) checkOne("ch0 post-reset rise k5", bus.o_rise, 4'b0001);
    end

`ifdef PIN_SYNCH_STICKY_EN
    checkOne("sticky set", bus.o_sticky, 4'b0001);
    applyStimulus(4'b0001, 4'b0001, "sticky clear");
    checkOne("sticky cleared", bus.o_sticky, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(4'b0000, (k == 6) ? 4'b0001 : 4'b0000, "sticky set vs clear");
      if (k == 6) checkOne("sticky set wins", bus.o_sticky, 4'b0001);
    end
`endif

    // Randomized pin activity with occasional sticky clears and one reset.
    lines = bus.i_asynchLines;
    for (int step = 0; step < 400; step++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(4) == 0) lines[ch] = ~lines[ch];
      end
      clr = NUM_CH'($urandom_range(15)) & NUM_CH'($urandom_range(15));
      applyStimulus(lines, clr, "random");
      if (step == 200) asyncReset("random reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
